// File: rtl/tx_frame_arbiter.sv
// Round-robin sequencer that shares one frame transmitter between NUM_REQ queues.
// Grants one queue per frame, waits for tx_done or a watchdog abort, then enforces an idle gap.
module tx_frame_arbiter #(
  parameter int unsigned NUM_REQ        = 4,
  parameter int unsigned IDX_W          = 2,
  parameter int unsigned IFG_CYCLES     = 12,
  parameter int unsigned TIMEOUT_CYCLES = 2048
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic               i_enable,
  input  logic [NUM_REQ-1:0] i_req,
  input  logic               i_tx_done,
  output logic [NUM_REQ-1:0] o_grant,
  output logic [IDX_W-1:0]   o_grant_idx,
  output logic               o_start_tx,
  output logic               o_tx_busy,
  output logic               o_timeout_err
);

  typedef enum logic [1:0] {StIdle, StWaitDone, StIfg} state_e;

  localparam logic [IDX_W:0] NUM_REQ_W = (IDX_W + 1)'(NUM_REQ);
  localparam logic [15:0]    WD_LAST   = 16'(TIMEOUT_CYCLES - 1);
  localparam logic [15:0]    IFG_LAST  = 16'(IFG_CYCLES - 1);

  state_e               r_state, w_state_nxt;
  logic [NUM_REQ-1:0]   r_grant, w_grant_nxt;
  logic [IDX_W-1:0]     r_grant_idx, w_grant_idx_nxt;
  logic [IDX_W-1:0]     r_rr_ptr, w_rr_ptr_nxt;
  logic                 r_start_tx, w_start_tx_nxt;
  logic                 r_tx_busy, w_tx_busy_nxt;
  logic                 r_timeout_err, w_timeout_err_nxt;
  logic [15:0]          r_wd_cnt, w_wd_cnt_nxt;
  logic [15:0]          r_ifg_cnt, w_ifg_cnt_nxt;

  logic                 w_found;
  logic [IDX_W-1:0]     w_pick_idx;
  logic [IDX_W:0]       w_cand;
  logic [IDX_W:0]       w_ptr_inc;

  // First requesting queue at or above the round-robin pointer, wrapping at NUM_REQ.
  always_comb begin
    w_found    = 1'b0;
    w_pick_idx = '0;
    w_cand     = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      w_cand = {1'b0, r_rr_ptr} + (IDX_W + 1)'(k);
      if (w_cand >= NUM_REQ_W) begin
        w_cand = w_cand - NUM_REQ_W;
      end
      if (!w_found && i_req[w_cand[IDX_W-1:0]]) begin
        w_found    = 1'b1;
        w_pick_idx = w_cand[IDX_W-1:0];
      end
    end
  end

  always_comb begin
    w_state_nxt       = r_state;
    w_grant_nxt       = r_grant;
    w_grant_idx_nxt   = r_grant_idx;
    w_rr_ptr_nxt      = r_rr_ptr;
    w_start_tx_nxt    = 1'b0;
    w_timeout_err_nxt = 1'b0;
    w_wd_cnt_nxt      = r_wd_cnt;
    w_ifg_cnt_nxt     = r_ifg_cnt;
    w_ptr_inc         = {1'b0, r_grant_idx} + 1'b1;
    if (w_ptr_inc == NUM_REQ_W) begin
      w_ptr_inc = '0;
    end

    case (r_state)
      StIdle: begin
        if (i_enable && w_found) begin
          w_grant_nxt     = NUM_REQ'(1) << w_pick_idx;
          w_grant_idx_nxt = w_pick_idx;
          w_start_tx_nxt  = 1'b1;
          w_wd_cnt_nxt    = '0;
          w_state_nxt     = StWaitDone;
        end
      end
      StWaitDone: begin
        // A done arriving on the timeout cycle wins and suppresses the error pulse.
        if (i_tx_done || (r_wd_cnt == WD_LAST)) begin
          w_grant_nxt       = '0;
          w_rr_ptr_nxt      = w_ptr_inc[IDX_W-1:0];
          w_ifg_cnt_nxt     = IFG_LAST;
          w_timeout_err_nxt = !i_tx_done;
          w_state_nxt       = StIfg;
        end else begin
          w_wd_cnt_nxt = r_wd_cnt + 16'd1;
        end
      end
      StIfg: begin
        if (r_ifg_cnt == '0) begin
          w_state_nxt = StIdle;
        end else begin
          w_ifg_cnt_nxt = r_ifg_cnt - 16'd1;
        end
      end
      default: begin
        w_state_nxt = StIdle;
        w_grant_nxt = '0;
      end
    endcase

    w_tx_busy_nxt = (w_state_nxt != StIdle);
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state       <= StIdle;
      r_grant       <= '0;
      r_grant_idx   <= '0;
      r_rr_ptr      <= '0;
      r_start_tx    <= 1'b0;
      r_tx_busy     <= 1'b0;
      r_timeout_err <= 1'b0;
      r_wd_cnt      <= '0;
      r_ifg_cnt     <= '0;
    end else begin
      r_state       <= w_state_nxt;
      r_grant       <= w_grant_nxt;
      r_grant_idx   <= w_grant_idx_nxt;
      r_rr_ptr      <= w_rr_ptr_nxt;
      r_start_tx    <= w_start_tx_nxt;
      r_tx_busy     <= w_tx_busy_nxt;
      r_timeout_err <= w_timeout_err_nxt;
      r_wd_cnt      <= w_wd_cnt_nxt;
      r_ifg_cnt     <= w_ifg_cnt_nxt;
    end
  end

  assign o_grant       = r_grant;
  assign o_grant_idx   = r_grant_idx;
  assign o_start_tx    = r_start_tx;
  assign o_tx_busy     = r_tx_busy;
  assign o_timeout_err = r_timeout_err;

endmodule

// File: tb/tb_tx_frame_arbiter.sv
// Bench for tx_frame_arbiter: cycle vector table, then multi-cycle sequences for
// rotation, idle-queue skipping, watchdog abort, enable gating and gap timing.
module tb_tx_frame_arbiter;

  logic       i_clk = 1'b0;
  logic       i_rst = 1'b1;
  logic       i_enable = 1'b0;
  logic [3:0] i_req = '0;
  logic       i_tx_done = 1'b0;
  logic [3:0] o_grant;
  logic [1:0] o_grant_idx;
  logic       o_start_tx;
  logic       o_tx_busy;
  logic       o_timeout_err;

  int total = 0;
  int bad   = 0;

  tx_frame_arbiter #(
    .NUM_REQ       (4),
    .IDX_W         (2),
    .IFG_CYCLES    (12),
    .TIMEOUT_CYCLES(2048)
  ) dut (
    .i_clk        (i_clk),
    .i_rst        (i_rst),
    .i_enable     (i_enable),
    .i_req        (i_req),
    .i_tx_done    (i_tx_done),
    .o_grant      (o_grant),
    .o_grant_idx  (o_grant_idx),
    .o_start_tx   (o_start_tx),
    .o_tx_busy    (o_tx_busy),
    .o_timeout_err(o_timeout_err)
  );

  always #5 i_clk = ~i_clk;

  typedef struct {
    logic       rst;
    logic       en;
    logic [3:0] req;
    logic       done;
    logic [3:0] g;
    logic [1:0] idx;
    logic       st;
    logic       busy;
    logic       to;
  } vec_t;

  logic [8:0] q_exp[$];   // packed {grant, idx, start, busy, timeout}
  logic [1:0] q_idx[$];   // expected grant order

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic do_reset();
    i_rst = 1'b1; i_enable = 1'b0; i_req = '0; i_tx_done = 1'b0;
    tick();
    tick();
    i_rst = 1'b0;
  endtask

  // Drives req, answers each start_tx with tx_done 5 cycles later, checks order and gaps.
  task automatic run_rr(input string nm, input logic [3:0] req, input int budget);
    int cd = 0;
    int low = 0;
    bit seen = 0;
    logic [1:0] e;
    i_enable = 1'b1; i_req = req; i_tx_done = 1'b0;
    for (int c = 0; c < budget && q_idx.size() > 0; c++) begin
      tick();
      i_tx_done = 1'b0;
      chk({nm, "_onehot"}, 32'(o_grant & (o_grant - 4'd1)), 32'd0);
      if (o_start_tx) begin
        e = q_idx.pop_front();
        chk({nm, "_idx"}, 32'(o_grant_idx), 32'(e));
        chk({nm, "_grant"}, 32'(o_grant), 32'(4'b0001 << e));
        if (seen) chk({nm, "_gap"}, low, 13);
        seen = 1'b1;
        low = 0;
        cd = 5;
      end else begin
        if (o_grant == '0) low++;
        if (cd > 0) begin
          cd--;
          if (cd == 0) i_tx_done = 1'b1;
        end
      end
    end
    if (q_idx.size() != 0) begin
      total++;
      bad++;
      $display("FAIL %s_budget: got %0d grants missing expected 0", nm, q_idx.size());
      q_idx.delete();
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got no end expected test done");
    $fatal(1);
  end

  initial begin
    vec_t vecs[15];
    logic [8:0] exp_v;
    int n;
    int m;
    int busy_cnt;
    int grant_cnt;
    int st_cnt;

    //          rst   en    req      done  grant    idx    st    busy  to
    vecs[0]  = '{1'b1, 1'b1, 4'b0001, 1'b0, 4'b0000, 2'd0, 1'b0, 1'b0, 1'b0};
    vecs[1]  = '{1'b0, 1'b1, 4'b0001, 1'b0, 4'b0001, 2'd0, 1'b1, 1'b1, 1'b0};
    vecs[2]  = '{1'b0, 1'b1, 4'b0001, 1'b0, 4'b0001, 2'd0, 1'b0, 1'b1, 1'b0};
    vecs[3]  = '{1'b0, 1'b1, 4'b0000, 1'b0, 4'b0001, 2'd0, 1'b0, 1'b1, 1'b0};
    vecs[4]  = '{1'b0, 1'b1, 4'b0000, 1'b1, 4'b0000, 2'd0, 1'b0, 1'b1, 1'b0};
    vecs[5]  = '{1'b0, 1'b1, 4'b0010, 1'b1, 4'b0000, 2'd0, 1'b0, 1'b1, 1'b0};
    vecs[6]  = '{1'b1, 1'b1, 4'b1111, 1'b0, 4'b0000, 2'd0, 1'b0, 1'b0, 1'b0};
    vecs[7]  = '{1'b0, 1'b0, 4'b1111, 1'b0, 4'b0000, 2'd0, 1'b0, 1'b0, 1'b0};
    vecs[8]  = '{1'b0, 1'b0, 4'b1111, 1'b1, 4'b0000, 2'd0, 1'b0, 1'b0, 1'b0};
    vecs[9]  = '{1'b0, 1'b1, 4'b1111, 1'b0, 4'b0001, 2'd0, 1'b1, 1'b1, 1'b0};
    vecs[10] = '{1'b0, 1'b1, 4'b1111, 1'b0, 4'b0001, 2'd0, 1'b0, 1'b1, 1'b0};
    vecs[11] = '{1'b1, 1'b1, 4'b1111, 1'b0, 4'b0000, 2'd0, 1'b0, 1'b0, 1'b0};
    vecs[12] = '{1'b0, 1'b0, 4'b1111, 1'b1, 4'b0000, 2'd0, 1'b0, 1'b0, 1'b0};
    vecs[13] = '{1'b0, 1'b1, 4'b1000, 1'b0, 4'b1000, 2'd3, 1'b1, 1'b1, 1'b0};
    vecs[14] = '{1'b0, 1'b0, 4'b1000, 1'b1, 4'b0000, 2'd3, 1'b0, 1'b1, 1'b0};

    tick();
    for (int i = 0; i < 15; i++) begin
      i_rst = vecs[i].rst; i_enable = vecs[i].en; i_req = vecs[i].req;
      i_tx_done = vecs[i].done;
      q_exp.push_back({vecs[i].g, vecs[i].idx, vecs[i].st, vecs[i].busy, vecs[i].to});
      tick();
      exp_v = q_exp.pop_front();
      chk($sformatf("vec%0d", i), 32'({o_grant, o_grant_idx, o_start_tx, o_tx_busy,
                                       o_timeout_err}), 32'(exp_v));
    end

    // Single frame, done 20 cycles after start_tx: busy for 33 cycles, grant for 21.
    do_reset();
    i_enable = 1'b1; i_req = 4'b0001;
    tick();
    chk("s1_grant", 32'(o_grant), 32'h1);
    chk("s1_start", 32'(o_start_tx), 32'h1);
    busy_cnt = int'(o_tx_busy); grant_cnt = int'(|o_grant); st_cnt = int'(o_start_tx);
    i_req = '0;
    for (int c = 0; c < 20; c++) begin
      tick();
      busy_cnt += int'(o_tx_busy); grant_cnt += int'(|o_grant); st_cnt += int'(o_start_tx);
    end
    i_tx_done = 1'b1;
    tick();
    i_tx_done = 1'b0;
    chk("s1_drop", 32'(o_grant), 32'h0);
    busy_cnt += int'(o_tx_busy); grant_cnt += int'(|o_grant); st_cnt += int'(o_start_tx);
    for (int c = 0; c < 40; c++) begin
      tick();
      busy_cnt += int'(o_tx_busy); grant_cnt += int'(|o_grant); st_cnt += int'(o_start_tx);
    end
    chk("s1_busy_cycles", busy_cnt, 33);
    chk("s1_grant_cycles", grant_cnt, 21);
    chk("s1_start_pulses", st_cnt, 1);

    // Full rotation with every queue requesting.
    do_reset();
    q_idx.push_back(2'd0); q_idx.push_back(2'd1); q_idx.push_back(2'd2);
    q_idx.push_back(2'd3); q_idx.push_back(2'd0);
    run_rr("rr_all", 4'b1111, 400);

    // Idle queues 0 and 2 are skipped.
    do_reset();
    q_idx.push_back(2'd1); q_idx.push_back(2'd3); q_idx.push_back(2'd1);
    run_rr("rr_sparse", 4'b1010, 300);

    // Watchdog abort, then the next queue after the gap.
    do_reset();
    i_enable = 1'b1; i_req = 4'b0011;
    tick();
    chk("to_first_idx", 32'(o_grant_idx), 32'd0);
    n = 0;
    for (int c = 0; c < 2100; c++) begin
      tick();
      n++;
      if (o_timeout_err) break;
    end
    chk("to_latency", n, 2048);
    chk("to_grant_clear", 32'(o_grant), 32'h0);
    m = 0;
    for (int c = 0; c < 40; c++) begin
      tick();
      m++;
      if (m == 1) chk("to_pulse_width", 32'(o_timeout_err), 32'h0);
      if (o_start_tx) break;
    end
    chk("to_regrant_gap", m, 13);
    chk("to_next_idx", 32'(o_grant_idx), 32'd1);

    // enable low mid-frame: frame completes, no new grant until re-enabled.
    do_reset();
    i_enable = 1'b1; i_req = 4'b0011;
    tick();
    chk("en_first_grant", 32'(o_grant), 32'h1);
    i_enable = 1'b0;
    for (int c = 0; c < 3; c++) tick();
    chk("en_hold_grant", 32'(o_grant), 32'h1);
    i_tx_done = 1'b1;
    tick();
    i_tx_done = 1'b0;
    chk("en_done_drop", 32'(o_grant), 32'h0);
    st_cnt = 0;
    for (int c = 0; c < 30; c++) begin
      tick();
      st_cnt += int'(o_start_tx);
    end
    chk("en_no_start", st_cnt, 0);
    chk("en_idle", 32'(o_tx_busy), 32'h0);
    i_enable = 1'b1;
    tick();
    chk("en_regrant_start", 32'(o_start_tx), 32'h1);
    chk("en_regrant_idx", 32'(o_grant_idx), 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/tx_frame_arbiter.md
Name: tx_frame_arbiter

Overview:
- Round-robin arbiter/sequencer sharing the single frame_transmission datapath between NUM_REQ transmit queues.
- Picks a requesting queue, grants it, and pulses start_tx to the transmitter.
- Holds the grant until tx_done, then enforces an inter-frame gap before the next grant.
- A watchdog aborts a frame whose tx_done never arrives.

Parameters:
NUM_REQ, 4, number of requesting queues (2..8)
IDX_W, 2, width of grant_idx; must equal clog2(NUM_REQ)
IFG_CYCLES, 12, idle clocks enforced after each frame (>=1)
TIMEOUT_CYCLES, 2048, max clocks in WAIT_DONE before abort (>=2, fits 16 bits)

Ports:
clk  in  1  system clock, all logic on rising edge
rst  in  1  synchronous, active-high reset
enable  in  1  1 = new grants allowed; 0 = finish current frame, then stay idle
req  in  NUM_REQ  bit i = queue i holds a complete frame ready to send
tx_done  in  1  one-cycle pulse from the transmitter: frame finished
grant  out  NUM_REQ  one-hot grant, held for the whole frame; selects the FIFO mux
grant_idx  out  IDX_W  binary index of the current/last grant
start_tx  out  1  one-cycle pulse to the transmitter
tx_busy  out  1  high whenever state != IDLE
timeout_err  out  1  one-cycle pulse when a frame is aborted by the watchdog

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous and active-high on rst.
- Reset values: state=IDLE, grant=0, grant_idx=0, start_tx=0, tx_busy=0, timeout_err=0, counters=0, rr pointer=0. Reset mid-frame drops the grant immediately and discards all counts.
- All outputs are registered.
- States: IDLE, WAIT_DONE, IFG.
- IDLE:
  - if enable && |req, choose the first set req bit searching upward from rr pointer, wrapping at NUM_REQ.
  - Next edge: grant<=onehot(i), grant_idx<=i, start_tx<=1, wd counter<=0, state<=WAIT_DONE.
  - Latency: req sampled at edge k gives grant and start_tx high from edge k+1.
- WAIT_DONE:
  - start_tx is high only in the first cycle.
  - The wd counter increments each cycle.
  - On tx_done: grant<=0, rr pointer<=(i+1) mod NUM_REQ, ifg counter<=IFG_CYCLES-1, state<=IFG.
  - If the wd counter reaches TIMEOUT_CYCLES-1 without tx_done: timeout_err<=1 for one cycle, then the same actions as tx_done (grant drop, pointer advance, IFG).
  - tx_done and timeout in the same cycle: treated as tx_done, no timeout_err.
- IFG: the counter decrements; at 0, state<=IDLE.
  - With req continuously pending, grant is low for exactly IFG_CYCLES+1 cycles between frames.
- tx_done is ignored in IDLE and IFG.
- Deassertion of the granted req during WAIT_DONE is ignored; the grant is held until done or timeout.
- enable only gates the IDLE decision; it never aborts a frame in progress.
- grant_idx retains its value after grant drops.
- Fairness: with all req bits set, grants rotate 0,1,2,…,NUM_REQ-1,0. The pointer advances past the served index only, not past skipped idle queues.
- grant is always zero or one-hot. Two grants must never overlap.

Test Plan:
- Reset, then req=4'b0001, tx_done 20 cycles after start_tx -> grant=0001 and start_tx one cycle after req; grant drops the edge after tx_done; tx_busy high for 20+12+1 cycles.
- req=4'b1111 held, tx_done 5 cycles after each start_tx -> grant_idx sequence 0,1,2,3,0. Gap between grants is exactly 13 cycles low.
- req=4'b1010 from reset -> first grant idx 1, then 3, then 1. Idle queues 0 and 2 are never granted.
- No tx_done after a grant, TIMEOUT_CYCLES=2048 -> timeout_err pulses one cycle exactly 2048 cycles after the start_tx cycle; grant clears; the next queue is granted after the IFG.
- enable=0 mid-frame with req pending -> current frame completes normally; no start_tx while enable=0. Re-enable -> grant within 1 cycle if in IDLE.
- Assert rst during WAIT_DONE, then tx_done arrives after reset -> all outputs 0 next edge; the stray tx_done is ignored; the next grant starts from queue 0.
